// File: rtl/pc_sequencer_if.sv
// Fetch-side bundle between the PC sequencer and its pipeline/memory/branch neighbours.
// The slave modport is the sequencer; the master modport is whoever drives it.
`timescale 1ns/1ps
interface pc_sequencer_if;
  logic        stall;
  logic        imemReady;
  logic        branchValid;
  logic [31:0] branchTo;
  logic        branchLink;
  logic [31:0] branchInstrPC;
  logic [31:0] pcAddress;
  logic        fetchValid;
  logic        flush;
  logic        linkWrite;
  logic [31:0] linkAddress;
  logic        alignErr;
  logic [15:0] redirectCount;

  modport master (
    output stall, imemReady, branchValid, branchTo, branchLink, branchInstrPC,
    input  pcAddress, fetchValid, flush, linkWrite, linkAddress, alignErr, redirectCount
  );

  modport slave (
    input  stall, imemReady, branchValid, branchTo, branchLink, branchInstrPC,
    output pcAddress, fetchValid, flush, linkWrite, linkAddress, alignErr, redirectCount
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential fetch, memory backpressure, branch redirect
// with a post-redirect flush window, link-register write and redirect statistics.
`timescale 1ns/1ps
module pc_sequencer #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input logic          clk,
  input logic          rst,
  pc_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_WAIT_MEM,
    ST_FLUSH
  } state_t;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t      state_reg;
  logic [31:0] pc_reg;
  logic [3:0]  flush_cnt_reg;
  logic        fetch_valid_reg;
  logic        link_write_reg;
  logic [31:0] link_address_reg;
  logic        align_err_reg;
  logic [15:0] redirect_count_reg;

  logic        advance;
  logic [31:0] pc_next;
  logic [31:0] redirect_pc;

  assign advance     = bus.imemReady & ~bus.stall;
  assign pc_next     = pc_reg + 32'd4;
  // branchTo arrives pre-decremented by 4, so the real target is one word further.
  assign redirect_pc = {bus.branchTo[31:2], 2'b00} + 32'd4;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg          <= ST_RUN;
      pc_reg             <= RESET_PC;
      flush_cnt_reg      <= 4'd0;
      fetch_valid_reg    <= 1'b0;
      link_write_reg     <= 1'b0;
      link_address_reg   <= 32'd0;
      align_err_reg      <= 1'b0;
      redirect_count_reg <= 16'd0;
    end else if (!fetch_valid_reg) begin
      // First edge after release only raises the fetch request; the PC holds.
      fetch_valid_reg <= 1'b1;
    end else begin
      link_write_reg <= 1'b0;
      align_err_reg  <= 1'b0;
      if (bus.branchValid) begin
        state_reg     <= ST_FLUSH;
        pc_reg        <= redirect_pc;
        flush_cnt_reg <= FLUSH_LOAD;
        align_err_reg <= |bus.branchTo[1:0];
        if (bus.branchLink) begin
          link_write_reg   <= 1'b1;
          link_address_reg <= bus.branchInstrPC + 32'd8;
        end
        if (redirect_count_reg != 16'hFFFF) begin
          redirect_count_reg <= redirect_count_reg + 16'd1;
        end
      end else begin
        case (state_reg)
          ST_RUN: begin
            if (!bus.imemReady) begin
              state_reg <= ST_WAIT_MEM;
            end else if (!bus.stall) begin
              pc_reg <= pc_next;
            end
          end
          ST_WAIT_MEM: begin
            if (bus.imemReady) begin
              state_reg <= ST_RUN;
              if (!bus.stall) begin
                pc_reg <= pc_next;
              end
            end
          end
          ST_FLUSH: begin
            if (advance) begin
              pc_reg <= pc_next;
            end
            if (flush_cnt_reg == 4'd0) begin
              state_reg <= ST_RUN;
            end else begin
              flush_cnt_reg <= flush_cnt_reg - 4'd1;
            end
          end
          default: state_reg <= ST_RUN;
        endcase
      end
    end
  end

  // The redirect cycle itself already kills younger work, hence the combinational term.
  assign bus.flush         = (bus.branchValid & fetch_valid_reg) | (state_reg == ST_FLUSH);
  assign bus.pcAddress     = pc_reg;
  assign bus.fetchValid    = fetch_valid_reg;
  assign bus.linkWrite     = link_write_reg;
  assign bus.linkAddress   = link_address_reg;
  assign bus.alignErr      = align_err_reg;
  assign bus.redirectCount = redirect_count_reg;

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, the PC value loaded at reset.
REQ-002 Parameter FLUSH_CYCLES, 2, the number of cycles flush stays high after a redirect; legal range is 1..15.
REQ-003 Port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1, asynchronous active-low reset.
REQ-005 Port stall, input, 1, hazard-unit hold request; when high the PC does not advance.
REQ-006 Port imemReady, input, 1, instruction memory accepted the fetch at pcAddress this cycle.
REQ-007 Port branchValid, input, 1, the branch unit's shouldUseNewPC, qualified by a valid instruction.
REQ-008 Port branchTo, input, 32, the branch unit's target; the value is pre-decremented by 4.
REQ-009 Port branchLink, input, 1, the redirecting instruction is a link form (BGEZAL/BLTZAL/JAL).
REQ-010 Port branchInstrPC, input, 32, the address of the redirecting instruction.
REQ-011 Port pcAddress, output, 32, the current fetch address; always word aligned.
REQ-012 Port fetchValid, output, 1, a fetch request is presented at pcAddress.
REQ-013 Port flush, output, 1, kill the younger instructions in fetch/decode.
REQ-014 Port linkWrite, output, 1, one-cycle pulse to write linkAddress to r31.
REQ-015 Port linkAddress, output, 32, the return address.
REQ-016 Port alignErr, output, 1, one-cycle pulse: branchTo[1:0] was nonzero.
REQ-017 Port redirectCount, output, 16, saturating count of accepted redirects.

Function
REQ-018 The state machine SHALL have three states:
- RUN: normal sequential fetch.
- WAIT_MEM: fetch outstanding, memory not ready.
- FLUSH: post-redirect kill window.

REQ-019 Advance rule: "advance" means imemReady=1 and stall=0. When advance is true, pcAddress SHALL become pcAddress+4 on the next edge, wrapping modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).

REQ-020 Priority: branchValid SHALL take priority over stall and imemReady in every state.

REQ-021 Redirect: on an edge with branchValid=1:
- pcAddress <= {branchTo[31:2],2'b00}+4;
- state <= FLUSH;
- flush counter <= FLUSH_CYCLES-1.

REQ-022 flush SHALL be asserted in the same cycle as branchValid (combinational) and in every cycle the state is FLUSH.

REQ-023 In FLUSH, the counter SHALL decrement each cycle. When the counter is 0 and branchValid=0, the state SHALL return to RUN.

REQ-024 A branchValid arriving while in FLUSH SHALL restart the redirect and reload the counter to FLUSH_CYCLES-1.

REQ-025 In FLUSH, the PC SHALL still advance under the advance rule.

REQ-026 From RUN, when imemReady=0 and branchValid=0, the state SHALL go to WAIT_MEM and the PC SHALL hold. The state SHALL return to RUN on the first edge with imemReady=1. The PC SHALL advance on that edge only if stall=0.

REQ-027 stall=1 with imemReady=1 SHALL hold the PC without a state change.

REQ-028 fetchValid SHALL be 1 in all states after reset release. It SHALL be 0 only while rst=0 and in the first cycle after release.

REQ-029 Link: on an edge with branchValid=1 and branchLink=1:
- linkWrite SHALL be 1 for exactly the next cycle;
- linkAddress SHALL be registered as branchInstrPC+8, modulo 2^32.

REQ-030 With branchLink=0, linkWrite SHALL stay 0 and linkAddress SHALL hold its value.

REQ-031 If branchValid=1 and branchTo[1:0]!=0, alignErr SHALL pulse for the next cycle. The redirect SHALL still occur, with the low bits forced to 0.

REQ-032 redirectCount SHALL increment on each edge with branchValid=1 and saturate at 16'hFFFF.

REQ-033 The PC update SHALL be registered only. The only combinational paths from inputs to outputs SHALL be branchValid -> flush.

Reset
REQ-034 While rst=0, outputs SHALL be:
- pcAddress=RESET_PC;
- state=RUN;
- fetchValid=0, flush=0, linkWrite=0, alignErr=0;
- linkAddress=0, redirectCount=0, flush counter=0.

REQ-035 Reset asserted mid-FLUSH or mid-WAIT_MEM SHALL abandon the operation immediately, with no pending redirect or link write surviving.

REQ-036 On the first edge after rst deasserts, fetchValid SHALL rise and the PC SHALL stay RESET_PC. The PC SHALL start advancing on the second edge.

Verification
REQ-037 Sequential fetch: reset, then imemReady=1, stall=0 for 4 cycles -> pcAddress 0,0,4,8,C. fetchValid=1 from cycle 1.

REQ-038 Redirect with link: at PC=0x20, drive:
- branchValid=1, branchTo=0x100, branchLink=1, branchInstrPC=0x1C.

Required response:
- next pcAddress=0x104;
- flush high for 2 cycles;
- linkWrite pulse with linkAddress=0x24;
- redirectCount=1.

REQ-039 Memory backpressure: imemReady=0 for 3 cycles at PC=0x40 -> PC holds at 0x40 in WAIT_MEM. imemReady=1 -> PC becomes 0x44. A branchValid asserted during WAIT_MEM with branchTo=0x200 -> PC becomes 0x204.

REQ-040 Back-to-back redirects: branchValid on two consecutive cycles (targets 0x100, 0x300) -> final PC=0x304, flush held 3 cycles total, redirectCount=2.

REQ-041 Boundaries:
- PC=0xFFFF_FFFC advances -> PC=0x0000_0000.
- branchTo=0x103 -> PC=0x104 and alignErr pulses.
- redirectCount preloaded at 0xFFFF by forcing 65535 redirects, then one more -> stays 0xFFFF.

REQ-042 Reset mid-FLUSH: assert rst=0 one cycle after a redirect -> all outputs at reset values immediately (asynchronous). No linkWrite is produced after release.
